// File: rtl/ps2_ascii_decoder.sv
// PS/2 Set-2 scancode to ASCII decoder with shift/caps tracking and a FWFT character FIFO.
// Optional caps lock handling is enabled by defining PS2_CAPS_LOCK_EN.
module ps2_ascii_decoder #(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned PTR_W      = $clog2(FIFO_DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       scan_code,
    input  logic             scan_valid,
    output logic [7:0]       ascii_data,
    output logic             ascii_valid,
    input  logic             ascii_ready,
    output logic [PTR_W:0]   fifo_count,
    output logic             overflow,
    output logic             shift_active,
    output logic             caps_active
);

    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, EXT, BREAK, EXT_BREAK} state_t;

    state_t           state;
    logic             lshift, rshift, lshift_n, rshift_n;
    logic             caps_n;
`ifdef PS2_CAPS_LOCK_EN
    logic             caps_held, caps_held_n;
`endif
    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr, wr_ptr, rd_next;
    logic [CNT_W-1:0] count_next;
    logic [7:0]       push_char, head_next;
    logic             is_prefix, make_n, make_e, brk_n;
    logic             pop, full, push, drop;

    // Normal-make lookup; 0x00 means the code produces no character.
    function automatic logic [7:0] map_normal(input logic [7:0] code, input logic shift,
                                              input logic upper);
        logic [7:0] c;
        c = 8'h00;
        case (code)
            8'h1C: c = 8'h61; 8'h32: c = 8'h62; 8'h21: c = 8'h63; 8'h23: c = 8'h64;
            8'h24: c = 8'h65; 8'h2B: c = 8'h66; 8'h34: c = 8'h67; 8'h33: c = 8'h68;
            8'h43: c = 8'h69; 8'h3B: c = 8'h6A; 8'h42: c = 8'h6B; 8'h4B: c = 8'h6C;
            8'h3A: c = 8'h6D; 8'h31: c = 8'h6E; 8'h44: c = 8'h6F; 8'h4D: c = 8'h70;
            8'h15: c = 8'h71; 8'h2D: c = 8'h72; 8'h1B: c = 8'h73; 8'h2C: c = 8'h74;
            8'h3C: c = 8'h75; 8'h2A: c = 8'h76; 8'h1D: c = 8'h77; 8'h22: c = 8'h78;
            8'h35: c = 8'h79; 8'h1A: c = 8'h7A;
            8'h45: c = shift ? 8'h29 : 8'h30;
            8'h16: c = shift ? 8'h21 : 8'h31;
            8'h1E: c = shift ? 8'h40 : 8'h32;
            8'h26: c = shift ? 8'h23 : 8'h33;
            8'h25: c = shift ? 8'h24 : 8'h34;
            8'h2E: c = shift ? 8'h25 : 8'h35;
            8'h36: c = shift ? 8'h5E : 8'h36;
            8'h3D: c = shift ? 8'h26 : 8'h37;
            8'h3E: c = shift ? 8'h2A : 8'h38;
            8'h46: c = shift ? 8'h28 : 8'h39;
            8'h4E: c = shift ? 8'h5F : 8'h2D;
            8'h55: c = shift ? 8'h2B : 8'h3D;
            8'h29: c = 8'h20;
            8'h5A: c = 8'h0A;
            8'h66: c = 8'h08;
            8'h70: c = 8'h30; 8'h69: c = 8'h31; 8'h72: c = 8'h32; 8'h7A: c = 8'h33;
            8'h6B: c = 8'h34; 8'h73: c = 8'h35; 8'h74: c = 8'h36; 8'h6C: c = 8'h37;
            8'h75: c = 8'h38; 8'h7D: c = 8'h39;
            8'h7B: c = 8'h2D; 8'h79: c = 8'h2B; 8'h7C: c = 8'h2A;
            default: c = 8'h00;
        endcase
        // Only the letter entries land in the lowercase range.
        if (upper && c >= 8'h61 && c <= 8'h7A) c = c - 8'h20;
        return c;
    endfunction

    always_comb begin
        is_prefix = (scan_code == 8'hE0) || (scan_code == 8'hF0);
        make_n    = scan_valid && (state == IDLE) && !is_prefix;
        make_e    = scan_valid && (state == EXT) && !is_prefix;
        brk_n     = scan_valid && (state == BREAK);

        push_char = 8'h00;
        if (make_n) begin
            push_char = map_normal(scan_code, shift_active, shift_active ^ caps_active);
        end else if (make_e) begin
            if (scan_code == 8'h4A) push_char = 8'h2F;
            else if (scan_code == 8'h5A) push_char = 8'h0A;
        end

        lshift_n = lshift;
        rshift_n = rshift;
        if (make_n && scan_code == 8'h12) lshift_n = 1'b1;
        if (make_n && scan_code == 8'h59) rshift_n = 1'b1;
        if (brk_n && scan_code == 8'h12)  lshift_n = 1'b0;
        if (brk_n && scan_code == 8'h59)  rshift_n = 1'b0;

        caps_n = caps_active;
`ifdef PS2_CAPS_LOCK_EN
        // Caps toggles once per physical press; typematic repeats are held off until release.
        caps_held_n = caps_held;
        if (make_n && scan_code == 8'h58 && !caps_held) begin
            caps_n      = !caps_active;
            caps_held_n = 1'b1;
        end
        if (brk_n && scan_code == 8'h58) caps_held_n = 1'b0;
`else
        caps_n = 1'b0;
`endif
    end

    // FIFO bookkeeping; the registered head is precomputed for the next cycle.
    always_comb begin
        pop        = ascii_valid && ascii_ready;
        full       = fifo_count == CNT_W'(FIFO_DEPTH);
        push       = (push_char != 8'h00) && (!full || pop);
        drop       = (push_char != 8'h00) && full && !pop;
        count_next = fifo_count + CNT_W'(push) - CNT_W'(pop);
        rd_next    = pop ? rd_ptr + PTR_W'(1) : rd_ptr;
        if (count_next == '0)
            head_next = 8'h00;
        else if (push && (fifo_count - CNT_W'(pop)) == '0)
            head_next = push_char;
        else
            head_next = mem[rd_next];
    end

    always_ff @(posedge clk) begin
        if (!rst && push) mem[wr_ptr] <= push_char;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            lshift       <= 1'b0;
            rshift       <= 1'b0;
`ifdef PS2_CAPS_LOCK_EN
            caps_held    <= 1'b0;
`endif
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            fifo_count   <= '0;
            ascii_valid  <= 1'b0;
            ascii_data   <= 8'h00;
            overflow     <= 1'b0;
            shift_active <= 1'b0;
            caps_active  <= 1'b0;
        end else begin
            if (scan_valid) begin
                case (state)
                    IDLE:    state <= (scan_code == 8'hE0) ? EXT :
                                      (scan_code == 8'hF0) ? BREAK : IDLE;
                    EXT:     state <= (scan_code == 8'hF0) ? EXT_BREAK :
                                      (scan_code == 8'hE0) ? EXT : IDLE;
                    default: state <= IDLE;
                endcase
            end
            lshift       <= lshift_n;
            rshift       <= rshift_n;
`ifdef PS2_CAPS_LOCK_EN
            caps_held    <= caps_held_n;
`endif
            shift_active <= lshift_n | rshift_n;
            caps_active  <= caps_n;
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            rd_ptr       <= rd_next;
            fifo_count   <= count_next;
            ascii_valid  <= count_next != '0;
            ascii_data   <= head_next;
            overflow     <= overflow | drop;
        end
    end

endmodule

// File: doc/ps2_ascii_decoder.md
Name: ps2_ascii_decoder

Overview:
- Clocked successor to the combinational scancode lookup; consumes PS/2 Set-2 scancode bytes from the receiver.
- Tracks make/break, E0-extended prefixes, left/right shift and caps lock.
- Emits true ASCII, including lowercase and shifted symbols, into a first-word-fall-through FIFO drained with a valid/ready handshake.
- Sits between the PS/2 byte receiver and the calculator/text consumer.

Parameters:
- FIFO_DEPTH, 8, character buffer entries; power of 2, ≥2.
- PTR_W, $clog2(FIFO_DEPTH), pointer width; derived, do not override.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- scan_code  in  8  scancode byte from the PS/2 receiver
- scan_valid  in  1  one-cycle strobe: scan_code is valid
- ascii_data  out  8  FIFO head character; 0x00 when empty
- ascii_valid  out  1  FIFO non-empty
- ascii_ready  in  1  consumer accepts the head this cycle
- fifo_count  out  PTR_W+1  occupancy
- overflow  out  1  sticky: a character was dropped
- shift_active  out  1  left or right shift held
- caps_active  out  1  caps lock state

Behaviour:
- Reset, applied on the clk edge while rst=1:
  - FSM goes to IDLE; FIFO empties.
  - All outputs go to 0: ascii_valid, ascii_data=0x00, fifo_count, overflow, shift_active, caps_active.
  - Reset mid-sequence discards any pending prefix and clears shift/caps.
- Prefix FSM, advanced only on scan_valid:
  - IDLE: E0→EXT; F0→BREAK; other bytes are a normal make, stay IDLE.
  - EXT: F0→EXT_BREAK; E0→EXT; other bytes are an extended make, then IDLE.
  - BREAK: any byte is a normal break, then IDLE.
  - EXT_BREAK: any byte is an extended break, then IDLE.
  - E1, AA and FA decode as unmapped bytes and produce no output.
- Modifiers:
  - Make 12 sets lshift; make 59 sets rshift. Break 12/59 clears the corresponding flag.
  - shift_active = lshift | rshift.
  - Make 58 toggles caps on the first make only. Typematic repeats are ignored until break 58.
  - Modifiers never push characters.
- Character mapping, on normal makes only:
  - Letters: lowercase 0x61–0x7A when shift XOR caps = 0, uppercase 0x41–0x5A otherwise.
  - Top-row digits unshifted 0–9. Shifted: 1! 2@ 3# 4$ 5% 6^ 7& 8* 9( 0).
  - 4E: '-' / '_'. 55: '=' / '+'.
  - 29 → 0x20 (space). 5A → 0x0A (enter). 66 → 0x08 (backspace).
  - Keypad 70,69,72,7A,6B,73,74,6C,75,7D → '0'–'9'. 7B '-', 79 '+', 7C '*'. Keypad keys ignore shift and caps.
- Extended makes: E0 4A → '/'; E0 5A → 0x0A. All other extended makes are ignored.
- All break codes push nothing. Unmapped codes push nothing.
- Typematic repeats push the character again on every make.
- FIFO:
  - Push on the clk edge of a mapped make. Data is visible on ascii_data/ascii_valid the next cycle (latency 1).
  - Pop when ascii_valid & ascii_ready.
  - Full with no same-cycle pop: the push is dropped and overflow is set (sticky until rst).
  - Full with a same-cycle pop: the push is accepted and count is unchanged.
  - Empty: a push and ascii_ready in the same cycle does not pop; the character appears next cycle.
  - Pointers wrap modulo FIFO_DEPTH. fifo_count ranges 0..FIFO_DEPTH.

Optional Feature:
- Macro: PS2_CAPS_LOCK_EN.
- Defined: caps lock behaves as above.
- Undefined: code 58 is ignored and caps_active is tied to 0, so letter case is set by shift alone.

Test Plan:
- rst, then 1C (scan_valid pulse) → one cycle later ascii_valid=1, ascii_data=0x61; pulse ascii_ready → ascii_valid=0, fifo_count=0.
- 12, 1C, F0 12, 1C → FIFO holds 0x41 then 0x61; shift_active is 1 between make 12 and break 12.
- 58, F0 58, 1C, 12, 1C (PS2_CAPS_LOCK_EN defined) → 0x41, 0x61, caps_active=1. Same stimulus with the macro undefined → 0x61, 0x41.
- E0 4A, E0 F0 4A, 7C, 12, 3E, 12, 75 → '/', '*', '*', '8' (0x2F, 0x2A, 0x2A, 0x38); no output from the break sequence.
- Hold ascii_ready=0 and push FIFO_DEPTH+1 characters → fifo_count=8, overflow=1, the ninth is dropped. Drain → the first eight appear in order. Then push while full with a simultaneous pop → accepted.
- Send F0, then assert rst, then 1C → 0x61 is pushed; the break prefix was discarded by reset.
